// File: rtl/timer_pkg.sv
// Shared constants for the FF04-FF07 timer block and its neighbours
// (address decoder, interrupt controller).
package timer_pkg;

    localparam logic [15:0] ADDR_DIV  = 16'hFF04;
    localparam logic [15:0] ADDR_TIMA = 16'hFF05;
    localparam logic [15:0] ADDR_TMA  = 16'hFF06;
    localparam logic [15:0] ADDR_TAC  = 16'hFF07;

    localparam int IRQ_TIMER_BIT = 2;
    localparam int TAC_EN_BIT    = 2;

    typedef enum logic [1:0] {
        TAC_4096   = 2'b00,
        TAC_262144 = 2'b01,
        TAC_65536  = 2'b10,
        TAC_16384  = 2'b11
    } tac_sel_e;

    function automatic logic is_timer_addr(input logic [15:0] addr);
        return (addr >= ADDR_DIV) && (addr <= ADDR_TAC);
    endfunction

endpackage

// File: rtl/timer_if.sv
// CPU-side register bus of the timer: decoder drives address/data/strobes,
// timer returns read data and the interrupt request.
interface timer_if;
    logic [15:0] A_timer;
    logic [7:0]  Di_timer;
    logic [7:0]  Do_timer;
    logic        cs_timer;
    logic        wr_timer;
    logic        rd_timer;
    logic        irq_timer;

    modport master (
        output A_timer, Di_timer, cs_timer, wr_timer, rd_timer,
        input  Do_timer, irq_timer
    );

    modport slave (
        input  A_timer, Di_timer, cs_timer, wr_timer, rd_timer,
        output Do_timer, irq_timer
    );
endinterface

// File: rtl/timer_edge_sel.sv
// TAC-selected counter tap with a registered copy and falling-edge detect;
// the falling edge is what advances TIMA.
module timer_edge_sel
    import timer_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [3:0] i_taps,   // counter bits ordered by TAC code: {b7, b5, b3, b9}
    input  logic [2:0] i_tac,
    output logic       o_fall
);

    tac_sel_e w_mode;
    logic     w_bit;
    logic     w_sel;
    logic     r_prev_sel;

    assign w_mode = tac_sel_e'(i_tac[1:0]);

    always_comb begin
        w_bit = 1'b0;
        unique case (w_mode)
            TAC_4096:   w_bit = i_taps[0];
            TAC_262144: w_bit = i_taps[1];
            TAC_65536:  w_bit = i_taps[2];
            TAC_16384:  w_bit = i_taps[3];
        endcase
    end

    // Gating by the enable bit means disabling the timer while the tap is high also counts.
    assign w_sel = i_tac[TAC_EN_BIT] & w_bit;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_prev_sel <= 1'b0;
        else          r_prev_sel <= w_sel;
    end

    assign o_fall = r_prev_sel & ~w_sel;

endmodule

// File: rtl/timer.sv
// Game Boy DIV/TIMA/TMA/TAC timer at FF04-FF07 with one-clock overflow IRQ.
// Define TIMER_RELOAD_DELAY_EN for the DMG-style 4-tick delayed TIMA reload.
module timer
    import timer_pkg::*;
#(
    parameter int CNT_W    = 16,
    parameter int TICK_DIV = 1
) (
    input logic    clk,
    input logic    rst_n,
    timer_if.slave bus
);

    logic [CNT_W-1:0] r_sys_cnt;
    logic [7:0]       r_tima;
    logic [7:0]       r_tma;
    logic [2:0]       r_tac;
    logic             r_irq;
    logic             w_tick;
    logic             w_wen;
    logic             w_wr_div, w_wr_tima, w_wr_tma, w_wr_tac;
    logic             w_fall;
    logic             w_ovf;
    logic [3:0]       w_taps;
    logic [7:0]       w_do;

    generate
        if (TICK_DIV <= 1) begin : g_no_pre
            assign w_tick = 1'b1;
        end else begin : g_pre
            localparam int PW = $clog2(TICK_DIV);
            logic [PW-1:0] r_pre;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)                          r_pre <= '0;
                else if (r_pre == PW'(TICK_DIV - 1)) r_pre <= '0;
                else                                 r_pre <= r_pre + 1'b1;
            end
            assign w_tick = (r_pre == PW'(TICK_DIV - 1));
        end
    endgenerate

    assign w_wen     = bus.wr_timer & bus.cs_timer & is_timer_addr(bus.A_timer);
    assign w_wr_div  = w_wen && (bus.A_timer == ADDR_DIV);
    assign w_wr_tima = w_wen && (bus.A_timer == ADDR_TIMA);
    assign w_wr_tma  = w_wen && (bus.A_timer == ADDR_TMA);
    assign w_wr_tac  = w_wen && (bus.A_timer == ADDR_TAC);

    assign w_taps = {r_sys_cnt[7], r_sys_cnt[5], r_sys_cnt[3], r_sys_cnt[9]};

    timer_edge_sel u_edge_sel (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_taps  (w_taps),
        .i_tac   (r_tac),
        .o_fall  (w_fall)
    );

    assign w_ovf = w_fall & (r_tima == 8'hFF);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sys_cnt <= '0;
            r_tma     <= 8'h00;
            r_tac     <= 3'b000;
        end else begin
            if (w_wr_div)    r_sys_cnt <= '0;
            else if (w_tick) r_sys_cnt <= r_sys_cnt + 1'b1;
            if (w_wr_tma)    r_tma <= bus.Di_timer;
            if (w_wr_tac)    r_tac <= bus.Di_timer[2:0];
        end
    end

`ifdef TIMER_RELOAD_DELAY_EN
    logic       r_rld_pend;
    logic [1:0] r_rld_cnt;
    logic       w_rld_now;

    assign w_rld_now = r_rld_pend & w_tick & (r_rld_cnt == 2'd3);

    // TIMA sits at 00 for four ticks after overflow, then takes the TMA current at that time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tima     <= 8'h00;
            r_irq      <= 1'b0;
            r_rld_pend <= 1'b0;
            r_rld_cnt  <= 2'd0;
        end else begin
            r_irq <= 1'b0;
            if (w_wr_tima) begin
                r_tima     <= bus.Di_timer;
                r_rld_pend <= 1'b0;
            end else if (w_rld_now) begin
                r_tima     <= r_tma;
                r_irq      <= 1'b1;
                r_rld_pend <= 1'b0;
            end else if (w_ovf) begin
                r_tima     <= 8'h00;
                r_rld_pend <= 1'b1;
                r_rld_cnt  <= 2'd0;
            end else if (w_fall) begin
                r_tima <= r_tima + 8'd1;
            end
            if (r_rld_pend && w_tick && !w_rld_now) r_rld_cnt <= r_rld_cnt + 2'd1;
        end
    end
`else
    // A CPU write to TIMA beats both increment and reload; the IRQ still fires on overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tima <= 8'h00;
            r_irq  <= 1'b0;
        end else begin
            r_irq <= w_ovf;
            if (w_wr_tima)   r_tima <= bus.Di_timer;
            else if (w_ovf)  r_tima <= r_tma;
            else if (w_fall) r_tima <= r_tima + 8'd1;
        end
    end
`endif

    always_comb begin
        w_do = 8'h00;
        if (bus.rd_timer && bus.cs_timer) begin
            case (bus.A_timer)
                ADDR_DIV:  w_do = r_sys_cnt[CNT_W-1 -: 8];
                ADDR_TIMA: w_do = r_tima;
                ADDR_TMA:  w_do = r_tma;
                ADDR_TAC:  w_do = {5'b11111, r_tac};
                default:   w_do = 8'h00;
            endcase
        end
    end

    assign bus.Do_timer  = w_do;
    assign bus.irq_timer = r_irq;

endmodule

// File: doc/timer.md
Name: timer

Overview:
- Game Boy DIV/TIMA/TMA/TAC timer occupying FF04-FF07.
- Sits directly downstream of the CPU address decoder, which produces its address, data, chip-select and read/write strobes.
- Produces read data back to the decoder and a one-cycle timer interrupt request for the interrupt controller (IF bit 2).

Parameters:
- CNT_W, 16, width of the internal system counter; DIV is bits [CNT_W-1:CNT_W-8].
- TICK_DIV, 1, clock cycles per T-cycle. The counter advances once every TICK_DIV clocks; 1 means clk is the 4.194304 MHz T-clock.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- A_timer  in  16  CPU address; only FF04-FF07 are decoded.
- Di_timer  in  8  write data from the CPU.
- Do_timer  out  8  read data to the CPU.
- cs_timer  in  1  chip select; address is in FF04-FF07.
- wr_timer  in  1  write strobe, already gated by cs_timer.
- rd_timer  in  1  read strobe, already gated by cs_timer.
- irq_timer  out  1  one-cycle interrupt request on TIMA overflow.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: sys_cnt=0, TIMA=00, TMA=00, TAC=0 (3 bits), irq_timer=0, prev_sel=0, tick prescaler=0.
- Read path: Do_timer is combinational, zero latency.
  - Do_timer = 00 when rd_timer=0 or cs_timer=0.
  - FF04 returns DIV.
  - FF05 returns TIMA.
  - FF06 returns TMA.
  - FF07 returns {5'b11111, TAC}.
- System counter: increments by 1 on each tick and wraps FFFF->0000.
  - tick is 1 every clock when TICK_DIV=1.
  - Otherwise tick pulses once per TICK_DIV clocks.
- Increment source select: sel = TAC[2] & sys_cnt[b].
  - b=9 for TAC[1:0]=00 (4096 Hz).
  - b=3 for 01 (262144 Hz).
  - b=5 for 10 (65536 Hz).
  - b=7 for 11 (16384 Hz).
- TIMA increment condition: the registered prev_sel==1 and the current sel==0 (falling edge). This is evaluated every clock, not only on tick.
- Writes: sampled on the rising clk edge when wr_timer=1.
  - FF04 (any value): clears sys_cnt to 0. If sel was 1, the resulting falling edge increments TIMA. This glitch is intended.
  - FF05: loads TIMA. A write wins over a simultaneous increment.
  - FF06: loads TMA.
  - FF07: loads TAC[2:0]. Any resulting 1->0 transition of sel also increments TIMA.
- Overflow: an increment with TIMA=FF produces the overflow event.
  - Base build: the same edge loads TIMA<=TMA and asserts irq_timer for exactly 1 clock.
  - TMA written in the same cycle as an overflow: the old TMA is loaded.
  - TIMA written in the same cycle as an overflow: the write wins and irq_timer still pulses.
- irq_timer is registered and high for one clock per overflow. It is never held.
- Reset asserted mid-operation: every register returns to its reset value immediately (asynchronous). A pending reload or irq is discarded.
- Writes outside FF04-FF07, or with cs_timer=0, are ignored.

Optional Feature:
- Macro: TIMER_RELOAD_DELAY_EN.
- Defined: models DMG delayed reload with a 2-bit delay counter.
  - On overflow, TIMA reads 00 for 4 ticks.
  - After the 4 ticks, TIMA<=TMA and irq_timer pulses. The TMA value used is the value current at reload time, so a TMA write during the window takes effect.
  - A TIMA write during the window cancels both the reload and the irq.
- Undefined: immediate reload and irq as in Behaviour; no delay counter is synthesized.

Decomposition:
- Shared package holds:
  - address constants ADDR_DIV=FF04, ADDR_TIMA=FF05, ADDR_TMA=FF06, ADDR_TAC=FF07;
  - the TAC select encodings;
  - the IRQ_TIMER_BIT=2 constant used by the interrupt controller.
- One natural sub-module, timer_edge_sel: a mux on sys_cnt bits selected by TAC, with prev_sel register and falling-edge detect. The rest stays in timer.

Test Plan:
- Reset: release rst_n, read FF04/FF05/FF06/FF07 -> 00/00/00/F8, irq_timer=0.
- DIV rate and write-clear:
  - run 256 ticks -> FF04 reads 01;
  - after 65536 ticks -> DIV wraps to 00;
  - write FF04=5A -> next read 00.
- TIMA rate: TAC=05, TIMA=00, 160 ticks -> TIMA=0A. Then TAC=04 and 1024 ticks -> TIMA increments by exactly 1.
- Overflow:
  - TMA=F0, TIMA=FE, TAC=05, 32 ticks -> TIMA=F0 with exactly one 1-cycle irq_timer pulse.
  - With TIMER_RELOAD_DELAY_EN: FF05 reads 00 for 4 ticks before F0.
- DIV-write glitch: TAC=05 and sys_cnt[3]=1, write FF04 -> TIMA +1 immediately. Repeat with sys_cnt[3]=0 -> TIMA unchanged.
- Collision: TIMA=FF and a write FF05=33 in the overflow cycle -> TIMA=33 (base build: irq still pulses). Assert rst_n low mid-count -> all registers 00 and irq_timer=0 asynchronously.
